mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the IF stage (fetch) and the MEM stage (LSU load/store).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_prio_sel.sv | 20 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/LSU RAM port arbiter.
// No logic, no latency.
// No flow control; types and constants only.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  // Reads always fetch the full word.
  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/arb_prio_sel.sv
// Winner select between fetch and LSU for the shared RAM port.
// Purely combinational, zero latency.
// No grant outside a slot; a killed fetch never wins, MEM wins by default.
module arb_prio_sel (
  input  logic slot,
  input  logic if_req,
  input  logic if_kill,
  input  logic mem_req,
  input  logic starve_hit,
  output logic if_win,
  output logic mem_win
);

  // MEM first, unless fetch has waited out its starvation budget.
  always_comb begin
    if_win  = slot && if_req && !if_kill && (!mem_req || starve_hit);
    mem_win = slot && mem_req && !if_win;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the LSU.
// Grant is combinational in the slot cycle; read data returns MEM_LAT cycles later.
// One access per MEM_LAT cycles; losing requester holds its request, o_busy stalls the pipe.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_kill,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_be,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_mem_gnt,
  output logic              o_mem_rvalid,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [3:0]        o_ram_be,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

  arb_state_e       state;
  owner_e           owner;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             kill_q;
  logic             we_q;
  logic             rst_q;

  logic done;
  logic slot;
  logic starve_hit;
  logic if_win;
  logic mem_win;
  logic if_rv;
  logic mem_rv;

  // Slot decode; rst_q blocks grants in the first cycle out of reset.
  always_comb begin
    done       = (state == ARB_WAIT) && (lat_cnt == LAT_DONE);
    slot       = !i_reset && !rst_q && ((state == ARB_IDLE) || done);
    starve_hit = (starve_cnt == STV_TOP);
  end

  arb_prio_sel u_prio_sel (
    .slot       (slot),
    .if_req     (i_if_req),
    .if_kill    (i_if_kill),
    .mem_req    (i_mem_req),
    .starve_hit (starve_hit),
    .if_win     (if_win),
    .mem_win    (mem_win)
  );

  // Drive the RAM with the winner's request only in the grant cycle.
  always_comb begin
    o_if_gnt    = if_win;
    o_mem_gnt   = mem_win;
    o_ram_en    = if_win || mem_win;
    o_ram_we    = mem_win && i_mem_we;
    o_ram_be    = 4'b0000;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (mem_win) begin
      o_ram_be    = i_mem_we ? i_mem_be : BE_ALL;
      o_ram_addr  = i_mem_addr;
      o_ram_wdata = i_mem_wdata;
    end else if (if_win) begin
      o_ram_be    = BE_ALL;
      o_ram_addr  = i_if_addr;
    end
  end

  // Steer returning RAM data to the owner; a kill in the completion cycle still counts.
  always_comb begin
    if_rv        = !i_reset && done && (owner == OWN_IF) && !kill_q && !i_if_kill;
    mem_rv       = !i_reset && done && (owner == OWN_MEM);
    o_if_rvalid  = if_rv;
    o_mem_rvalid = mem_rv;
    o_if_rdata   = if_rv ? i_ram_rdata : '0;
    o_mem_rdata  = (mem_rv && !we_q) ? i_ram_rdata : '0;
    o_busy       = !i_reset && (state == ARB_WAIT) && !done;
  end

  // Access FSM: owner, latency count and sticky fetch-kill.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ARB_IDLE;
      owner   <= OWN_NONE;
      lat_cnt <= '0;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (if_win || mem_win) begin
        state   <= ARB_WAIT;
        owner   <= if_win ? OWN_IF : OWN_MEM;
        lat_cnt <= LAT_W'(1);
        kill_q  <= 1'b0;
        we_q    <= mem_win && i_mem_we;
      end else if (done) begin
        state   <= ARB_IDLE;
        owner   <= OWN_NONE;
        lat_cnt <= '0;
        kill_q  <= 1'b0;
        we_q    <= 1'b0;
      end else if (state == ARB_WAIT) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
        if ((owner == OWN_IF) && i_if_kill) begin
          kill_q <= 1'b1;
        end
      end
    end
  end

  // Count MEM wins while fetch waits; any fetch grant or uncontested MEM grant clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (mem_win) begin
      if (!i_if_req) begin
        starve_cnt <= '0;
      end else if (!starve_hit) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_if_kill;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [3:0]  i_mem_be;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic        o_mem_gnt;
  logic        o_mem_rvalid;
  logic [31:0] o_mem_rdata;
  logic        o_ram_en;
  logic        o_ram_we;
  logic [3:0]  o_ram_be;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;
  logic        o_busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_kill(i_if_kill),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_be(i_mem_be),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_mem_gnt(o_mem_gnt), .o_mem_rvalid(o_mem_rvalid), .o_mem_rdata(o_mem_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_be(o_ram_be),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: two-cycle read latency, byte-enabled writes.
  logic [31:0] ram [0:1023];
  logic [31:0] rd0 = 32'h0;
  logic [31:0] rd1 = 32'h0;
  always @(posedge clk) begin
    if (o_ram_en) begin
      rd0 <= ram[o_ram_addr[11:2]];
      if (o_ram_we)
        for (int b = 0; b < 4; b++)
          if (o_ram_be[b]) ram[o_ram_addr[11:2]][8*b +: 8] <= o_ram_wdata[8*b +: 8];
    end else begin
      rd0 <= 32'h5A5A_0000 | 32'(cyc & 16'hFFFF);
    end
    rd1 <= rd0;
  end
  assign i_ram_rdata = rd1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    int          due;
  } sb_t;
  sb_t sb_if[$];
  sb_t sb_mem[$];
  sb_t mon_e;

  // Scoreboard consumer: every rvalid must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (o_if_rvalid) begin
      if (sb_if.size() == 0) chk("if_unexpected_rvalid", 1, 0);
      else begin
        mon_e = sb_if.pop_front();
        chk("if_rdata", o_if_rdata, mon_e.d);
        chk("if_rvalid_cycle", cyc, mon_e.due);
      end
    end else chk("if_rdata_idle", o_if_rdata, 0);
    if (o_mem_rvalid) begin
      if (sb_mem.size() == 0) chk("mem_unexpected_rvalid", 1, 0);
      else begin
        mon_e = sb_mem.pop_front();
        chk("mem_rdata", o_mem_rdata, mon_e.d);
        chk("mem_rvalid_cycle", cyc, mon_e.due);
      end
    end else chk("mem_rdata_idle", o_mem_rdata, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb_if.size() != 0 || sb_mem.size() != 0) && k < 12) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(sb_if.size() + sb_mem.size()), 0);
    tick();
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic do_txn(input vec_t v, input int id);
    bit got = 0;
    if (v.is_mem) begin
      i_mem_req = 1; i_mem_we = v.we; i_mem_be = v.be; i_mem_addr = v.addr; i_mem_wdata = v.wdata;
    end else begin
      i_if_req = 1; i_if_addr = v.addr;
    end
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (o_ram_en) begin
        got = 1;
        chk($sformatf("vec%0d_gnt", id), v.is_mem ? o_mem_gnt : o_if_gnt, 1);
        chk($sformatf("vec%0d_ram_we", id), o_ram_we, v.we);
        chk($sformatf("vec%0d_ram_be", id), o_ram_be, v.exp_be);
        chk($sformatf("vec%0d_ram_addr", id), o_ram_addr, v.addr);
        if (v.we) chk($sformatf("vec%0d_ram_wdata", id), o_ram_wdata, v.wdata);
        if (v.is_mem) sb_mem.push_back('{v.exp_rdata, cyc + 2});
        else          sb_if.push_back('{v.exp_rdata, cyc + 2});
      end
      tick();
    end
    chk($sformatf("vec%0d_gnt_timeout", id), 32'(got), 1);
    i_if_req = 0; i_mem_req = 0; i_mem_we = 0; i_mem_be = 0;
    drain();
  endtask

  vec_t vecs[8];

  initial begin
    int mg[$];
    int ig;
    int first;

    // Stimulus table: {is_mem, we, be, addr, wdata, exp_be, exp_rdata}
    vecs[0] = '{0, 0, 4'b0000, 32'h0000_0000, 32'h0,         4'b1111, 32'h0050_0093};
    vecs[1] = '{1, 1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 32'h0};
    vecs[2] = '{1, 0, 4'b0001, 32'h0000_0200, 32'h0,         4'b1111, 32'h0000_BEEF};
    vecs[3] = '{1, 1, 4'b1111, 32'h0000_0204, 32'h1234_5678, 4'b1111, 32'h0};
    vecs[4] = '{0, 0, 4'b0000, 32'h0000_0204, 32'h0,         4'b1111, 32'h1234_5678};
    vecs[5] = '{1, 1, 4'b1100, 32'h0000_0208, 32'hCAFE_F00D, 4'b1100, 32'h0};
    vecs[6] = '{1, 0, 4'b0000, 32'h0000_0208, 32'h0,         4'b1111, 32'hCAFE_0000};
    vecs[7] = '{0, 0, 4'b0000, 32'h0000_0004, 32'h0,         4'b1111, 32'h0010_0113};

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[0]    = 32'h0050_0093;
    ram[1]    = 32'h0010_0113;
    ram[10'h40] = 32'h0BAD_F00D;

    i_reset = 1; i_if_req = 1; i_if_addr = 0; i_if_kill = 0;
    i_mem_req = 0; i_mem_we = 0; i_mem_be = 0; i_mem_addr = 0; i_mem_wdata = 0;

    // Reset: outputs quiet even with a request pending.
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("rst_if_gnt", o_if_gnt, 0);
      chk("rst_ram_en", o_ram_en, 0);
      chk("rst_busy", o_busy, 0);
    end
    tick();
    i_reset = 0;
    @(negedge clk);
    chk("post_rst_if_gnt", o_if_gnt, 0);
    chk("post_rst_ram_en", o_ram_en, 0);
    tick();
    @(negedge clk);
    chk("first_if_gnt", o_if_gnt, 1);
    chk("first_ram_addr", o_ram_addr, 0);
    chk("first_ram_be", o_ram_be, 4'b1111);
    sb_if.push_back('{32'h0050_0093, cyc + 2});
    tick();
    i_if_req = 0;
    @(negedge clk);
    chk("first_busy", o_busy, 1);
    drain();

    // Table of single accesses.
    for (int i = 0; i < 8; i++) do_txn(vecs[i], i);

    // Contention: MEM wins, IF takes the completion slot.
    i_if_req = 1; i_if_addr = 32'h4;
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h100;
    @(negedge clk);
    chk("cont_mem_gnt", o_mem_gnt, 1);
    chk("cont_if_gnt_t0", o_if_gnt, 0);
    sb_mem.push_back('{32'h0BAD_F00D, cyc + 2});
    tick();
    i_mem_req = 0;
    @(negedge clk);
    chk("cont_if_gnt_t1", o_if_gnt, 0);
    chk("cont_busy_t1", o_busy, 1);
    tick();
    @(negedge clk);
    chk("cont_if_gnt_t2", o_if_gnt, 1);
    chk("cont_busy_t2", o_busy, 0);
    sb_if.push_back('{32'h0010_0113, cyc + 2});
    tick();
    i_if_req = 0;
    drain();

    // Starvation: MEM held high wins four times, then fetch wins.
    i_if_req = 1; i_if_addr = 32'h4;
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h100;
    ig = -1;
    for (int k = 0; k < 20 && ig < 0; k++) begin
      @(negedge clk);
      if (o_mem_gnt) begin
        mg.push_back(cyc);
        sb_mem.push_back('{32'h0BAD_F00D, cyc + 2});
      end
      if (o_if_gnt) begin
        ig = cyc;
        sb_if.push_back('{32'h0010_0113, cyc + 2});
      end
      tick();
    end
    i_if_req = 0; i_mem_req = 0;
    first = (mg.size() > 0) ? mg[0] : -1000;
    chk("starve_mem_gnts", 32'(mg.size()), 4);
    chk("starve_if_gnt_offset", 32'(ig - first), 8);
    for (int i = 1; i < mg.size(); i++)
      chk($sformatf("starve_mem_gnt%0d_offset", i), 32'(mg[i] - first), 32'(2 * i));
    drain();

    // Kill: killed fetch returns nothing, slot goes to MEM on time.
    i_if_req = 1; i_if_addr = 32'h0;
    @(negedge clk);
    chk("kill_if_gnt", o_if_gnt, 1);
    tick();
    i_if_req = 0; i_if_kill = 1;
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h100;
    @(negedge clk);
    chk("kill_mem_gnt_t1", o_mem_gnt, 0);
    chk("kill_busy_t1", o_busy, 1);
    tick();
    i_if_kill = 0;
    @(negedge clk);
    chk("kill_if_rvalid", o_if_rvalid, 0);
    chk("kill_mem_gnt_t2", o_mem_gnt, 1);
    sb_mem.push_back('{32'h0BAD_F00D, cyc + 2});
    tick();
    i_mem_req = 0;
    drain();

    // Reset mid-access: access abandoned, first new grant one cycle after reset drops.
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h100;
    @(negedge clk);
    chk("rmid_mem_gnt", o_mem_gnt, 1);
    tick();
    i_mem_req = 0; i_reset = 1;
    @(negedge clk);
    chk("rmid_ram_en", o_ram_en, 0);
    chk("rmid_busy", o_busy, 0);
    chk("rmid_mem_rvalid_t1", o_mem_rvalid, 0);
    tick();
    i_reset = 0; i_mem_req = 1;
    @(negedge clk);
    chk("rmid_mem_rvalid_t2", o_mem_rvalid, 0);
    chk("rmid_mem_gnt_t2", o_mem_gnt, 0);
    chk("rmid_ram_en_t2", o_ram_en, 0);
    tick();
    @(negedge clk);
    chk("rmid_mem_gnt_t3", o_mem_gnt, 1);
    sb_mem.push_back('{32'h0BAD_F00D, cyc + 2});
    tick();
    i_mem_req = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
